// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU datapath leaf blocks: the
//                add/subtract opcode encodings and the default operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam int   ADDSUB_W = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder. It is one stage of the ripple-carry
//                chain in four_bit_add_sub.
//  Ports       : a, b   - operand bits
//                cin    - carry in
//                s      - sum bit
//                cout   - carry out (majority of a, b, cin)
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/four_bit_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_add_sub
//  Description : Registered two's-complement adder/subtractor. A ripple chain
//                of full adders computes A+B (Op=0) or A-B (Op=1). For
//                subtraction, B is inverted and the carry-in is set to 1.
//                The result, carry-out and signed overflow are registered, so
//                the block has a latency of one cycle.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset (clears all outputs)
//                A, B - WIDTH-bit operands
//                Op   - 0 = add, 1 = subtract
//                S    - registered result, modulo 2^WIDTH
//                C    - registered carry-out of the MSB stage
//                       (for subtraction, 1 = no borrow)
//                V    - registered signed-overflow flag
//                Z    - registered zero flag. This port exists only when the
//                       ZERO_FLAG_EN macro is defined.
//  Config      : `define ZERO_FLAG_EN to add the Z output.
//  Revision    : 1.0  initial release
// ============================================================================
module four_bit_add_sub
   import alu_pkg::*;
#(
   parameter int WIDTH = ADDSUB_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Op,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V
`ifdef ZERO_FLAG_EN
   ,
   output logic             Z
`endif
);

   logic             w_sub;
   logic [WIDTH-1:0] w_b_inv;
   logic [WIDTH:0]   w_carry;

   logic [WIDTH-1:0] s_d, s_q;
   logic             c_d, c_q;
   logic             v_d, v_q;

   // Subtraction is A + ~B + 1. The +1 enters through the carry-in of stage 0.
   assign w_sub      = (Op == OP_SUB);
   assign w_b_inv    = B ^ {WIDTH{w_sub}};
   assign w_carry[0] = w_sub;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_stage
         full_adder u_fa (
            .a    (A[i]),
            .b    (w_b_inv[i]),
            .cin  (w_carry[i]),
            .s    (s_d[i]),
            .cout (w_carry[i+1])
         );
      end
   endgenerate

   assign c_d = w_carry[WIDTH];
   // Overflow occurs when the carry into the sign bit differs from the carry
   // out of the sign bit.
   assign v_d = w_carry[WIDTH] ^ w_carry[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= '0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         s_q <= s_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign S = s_q;
   assign C = c_q;
   assign V = v_q;

`ifdef ZERO_FLAG_EN
   logic z_d, z_q;

   assign z_d = (s_d == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q <= 1'b0;
      end else begin
         z_q <= z_d;
      end
   end

   assign Z = z_q;
`endif

endmodule : four_bit_add_sub
`default_nettype wire

// File: tb/tb_four_bit_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_four_bit_add_sub
//  Description : Scoreboard bench for four_bit_add_sub. The driver applies
//                operands on the falling edge and queues the expected
//                response. The monitor pops one entry after each rising edge
//                and compares it against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_four_bit_add_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] A   = '0;
   logic [3:0] B   = '0;
   logic       Op  = 1'b0;
   logic [3:0] S;
   logic       C;
   logic       V;
`ifdef ZERO_FLAG_EN
   logic       Z;
`endif

   four_bit_add_sub #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .Op  (Op),
      .S   (S),
      .C   (C),
      .V   (V)
`ifdef ZERO_FLAG_EN
      ,
      .Z   (Z)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] s;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t mk(input int s, input int c, input int v);
      exp_t e;
      e.s = s[3:0];
      e.c = c[0];
      e.v = v[0];
      e.z = (s[3:0] == 4'd0);
      return e;
   endfunction

   // Reference model: integer arithmetic and a signed range check.
   function automatic exp_t golden(input logic [3:0] a, input logic [3:0] b, input logic op);
      int r;
      int sa;
      int sbv;
      int sr;
      r   = op ? (int'(a) + int'(4'(~b)) + 1) : (int'(a) + int'(b));
      sa  = a[3] ? int'(a) - 16 : int'(a);
      sbv = b[3] ? int'(b) - 16 : int'(b);
      sr  = op ? sa - sbv : sa + sbv;
      return mk(r & 15, (r >> 4) & 1, ((sr > 7) || (sr < -8)) ? 1 : 0);
   endfunction

   task automatic check(input string name, input exp_t e);
      logic z_act;
`ifdef ZERO_FLAG_EN
      z_act = Z;
`else
      z_act = e.z;
`endif
      n_tests++;
      if (S !== e.s || C !== e.c || V !== e.v || z_act !== e.z) begin
         n_fail++;
         $display("FAIL %s: got S=%0d C=%b V=%b Z=%b, expected S=%0d C=%b V=%b Z=%b",
                  name, S, C, V, z_act, e.s, e.c, e.v, e.z);
      end
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic op, input exp_t e);
      @(negedge clk);
      A  = a;
      B  = b;
      Op = op;
      sb_q.push_back(e);
   endtask

   // Monitor: each queued vector is captured on the next rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("scoreboard", e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ra, rb;
      logic       rop;

      // Check the outputs while reset is held from time zero.
      #2;
      check("reset_initial", mk(0, 0, 0));
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with hand-computed expected results.
      apply(4'd3,  4'd4,  1'b0, mk(7,  0, 0));
      apply(4'd3,  4'd4,  1'b1, mk(15, 0, 0));
      apply(4'd0,  4'd5,  1'b0, mk(5,  0, 0));
      apply(4'd0,  4'd5,  1'b1, mk(11, 0, 0));
      apply(4'd9,  4'd2,  1'b0, mk(11, 0, 0));
      apply(4'd9,  4'd2,  1'b1, mk(7,  1, 1));
      apply(4'd10, 4'd10, 1'b0, mk(4,  1, 1));
      apply(4'd10, 4'd10, 1'b1, mk(0,  1, 0));
      apply(4'd15, 4'd15, 1'b1, mk(0,  1, 0));
      apply(4'd7,  4'd1,  1'b0, mk(8,  0, 1));
      apply(4'd8,  4'd1,  1'b1, mk(7,  1, 1));
      apply(4'd15, 4'd15, 1'b0, mk(14, 1, 0));

      // Assert reset mid-run while the outputs are nonzero. Reset must clear
      // them at once, without waiting for a clock edge.
      @(negedge clk);
      check("pre_reset_nonzero", mk(14, 1, 0));
      #1;
      rst = 1'b1;
      #1;
      check("reset_async", mk(0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         check("reset_held", mk(0, 0, 0));
      end
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back random vectors.
      for (int i = 0; i < 50; i++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rop = 1'($urandom_range(0, 1));
         apply(ra, rb, rop, golden(ra, rb, rop));
      end

      // Exhaustive sweep over all A, B and Op.
      for (int op = 0; op < 2; op++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               apply(4'(a), 4'(b), 1'(op), golden(4'(a), 4'(b), 1'(op)));
            end
         end
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
         @(posedge clk);
         #3;
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_four_bit_add_sub
`default_nettype wire
